// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris input path and the game-logic FSM.
// Holds the command-code encoding and the pending-source bit indices.
package tetris_pkg;

  localparam int CMD_W = 3;

  // Command codes sent from the sequencer to game logic. 6 and 7 are unused.
  typedef enum logic [CMD_W-1:0] {
    CMD_NONE  = 3'd0,
    CMD_LEFT  = 3'd1,
    CMD_RIGHT = 3'd2,
    CMD_ROT   = 3'd3,
    CMD_FALL  = 3'd4,
    CMD_DROP  = 3'd5
  } cmd_e;

  // Bit positions in the pending vector. Higher index means higher priority.
  localparam int N_SRC     = 5;
  localparam int SRC_FALL  = 0;
  localparam int SRC_RIGHT = 1;
  localparam int SRC_LEFT  = 2;
  localparam int SRC_ROT   = 3;
  localparam int SRC_DROP  = 4;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for game-move commands.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_flush            synchronous empty (takes priority over push/pop)
//   i_push, i_wdata    write request and data
//   i_pop              read request (ignored when empty)
//   o_rdata            entry at the head
//   o_full, o_empty    occupancy flags
//   o_count            current occupancy, 0..DEPTH
// A push while full is accepted only when a pop happens on the same edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tetris_cmd_sequencer.sv
// Turns debounced button press pulses plus an auto-fall timer into an
// ordered stream of game-move commands for the game-logic FSM.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   left_p, right_p, rot_p, drop_p   one-cycle press pulses
//   level                            game level 0..15, sets gravity speed
//   gravity_en                       run enable for the gravity timer
//   clear                            synchronous flush of all queued work
//   cmd_valid, cmd_code, cmd_ready   valid/ready command handshake
//   fifo_count                       queued command count
//   dropped                          one-cycle pulse when a press is coalesced
// Each source has a pending bit; one bit per cycle is moved into the FIFO by
// fixed priority DROP > ROT > LEFT > RIGHT > FALL.
module tetris_cmd_sequencer
  import tetris_pkg::*;
#(
  parameter int CLK_TICKS_BASE = 50_000_000,
  parameter int LEVEL_STEP     = 4_000_000,
  parameter int MIN_PERIOD     = 5_000_000,
  parameter int CNT_W          = 26,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        left_p,
  input  logic                        right_p,
  input  logic                        rot_p,
  input  logic                        drop_p,
  input  logic [3:0]                  level,
  input  logic                        gravity_en,
  input  logic                        clear,
  output logic                        cmd_valid,
  output logic [CMD_W-1:0]            cmd_code,
  input  logic                        cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        dropped
);

  // Extra headroom so level*LEVEL_STEP can exceed the base without wrapping.
  localparam int PW = CNT_W + 5;

  logic [N_SRC-1:0] r_pend;
  logic [CNT_W-1:0] r_grav_cnt;
  logic             r_dropped;

  logic [PW-1:0]    w_step_total;
  logic [PW-1:0]    w_period;
  logic [PW-1:0]    w_period_m1;
  logic             w_grav_tick;
  logic             w_fall_set;

  logic [N_SRC-1:0] w_sel_mask;
  logic [CMD_W-1:0] w_sel_code;
  logic [N_SRC-1:0] w_clr_mask;
  logic [N_SRC-1:0] w_set_vec;
  logic             w_push;
  logic             w_drop_push;
  logic             w_pop;

  logic [CMD_W-1:0] w_rdata;
  logic             w_full;
  logic             w_empty;

  // Gravity period with saturation at MIN_PERIOD.
  always_comb begin
    w_step_total = PW'(level) * PW'(LEVEL_STEP);
    if ((w_step_total + PW'(MIN_PERIOD)) > PW'(CLK_TICKS_BASE)) begin
      w_period = PW'(MIN_PERIOD);
    end else begin
      w_period = PW'(CLK_TICKS_BASE) - w_step_total;
    end
    w_period_m1 = w_period - PW'(1);
  end

  // >= rather than == so a level increase mid-count fires right away.
  assign w_grav_tick = gravity_en && (PW'(r_grav_cnt) >= w_period_m1);

  // Fixed-priority pick of one pending source.
  always_comb begin
    w_sel_mask = '0;
    w_sel_code = CMD_NONE;
    if (r_pend[SRC_DROP]) begin
      w_sel_mask[SRC_DROP] = 1'b1;
      w_sel_code           = CMD_DROP;
    end else if (r_pend[SRC_ROT]) begin
      w_sel_mask[SRC_ROT] = 1'b1;
      w_sel_code          = CMD_ROT;
    end else if (r_pend[SRC_LEFT]) begin
      w_sel_mask[SRC_LEFT] = 1'b1;
      w_sel_code           = CMD_LEFT;
    end else if (r_pend[SRC_RIGHT]) begin
      w_sel_mask[SRC_RIGHT] = 1'b1;
      w_sel_code            = CMD_RIGHT;
    end else if (r_pend[SRC_FALL]) begin
      w_sel_mask[SRC_FALL] = 1'b1;
      w_sel_code           = CMD_FALL;
    end
  end

  assign w_pop       = cmd_ready && !w_empty;
  assign w_push      = !clear && (|r_pend) && (!w_full || w_pop);
  assign w_drop_push = w_push && w_sel_mask[SRC_DROP];

  // A hard drop lands the piece, so a gravity tick on that same edge is moot.
  assign w_fall_set  = w_grav_tick && !w_drop_push;

  always_comb begin
    w_set_vec            = '0;
    w_set_vec[SRC_DROP]  = drop_p;
    w_set_vec[SRC_ROT]   = rot_p;
    w_set_vec[SRC_LEFT]  = left_p;
    w_set_vec[SRC_RIGHT] = right_p;
    w_set_vec[SRC_FALL]  = w_fall_set;

    w_clr_mask = '0;
    if (w_push) begin
      w_clr_mask = w_sel_mask;
    end
    if (w_drop_push) begin
      w_clr_mask[SRC_FALL] = 1'b1;
    end
  end

  // Set wins over the enqueue clear, so a press in the enqueue cycle is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_dropped <= 1'b0;
    end else if (clear) begin
      r_pend    <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_pend    <= (r_pend & ~w_clr_mask) | w_set_vec;
      r_dropped <= |(w_set_vec & r_pend & ~w_clr_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grav_cnt <= '0;
    end else if (clear || !gravity_en || w_drop_push || w_grav_tick) begin
      r_grav_cnt <= '0;
    end else begin
      r_grav_cnt <= r_grav_cnt + CNT_W'(1);
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (clear),
    .i_push  (w_push),
    .i_wdata (w_sel_code),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign cmd_valid = !w_empty;
  assign cmd_code  = w_empty ? CMD_NONE : w_rdata;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_tetris_cmd_sequencer.sv
module tb_tetris_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       left_p = 1'b0;
  logic       right_p = 1'b0;
  logic       rot_p = 1'b0;
  logic       drop_p = 1'b0;
  logic [3:0] level = 4'd0;
  logic       gravity_en = 1'b0;
  logic       clear = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [2:0] fifo_count;
  logic       dropped;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tetris_cmd_sequencer #(
    .CLK_TICKS_BASE (20),
    .LEVEL_STEP     (4),
    .MIN_PERIOD     (6),
    .CNT_W          (26),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .left_p     (left_p),
    .right_p    (right_p),
    .rot_p      (rot_p),
    .drop_p     (drop_p),
    .level      (level),
    .gravity_en (gravity_en),
    .clear      (clear),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .fifo_count (fifo_count),
    .dropped    (dropped)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held: pulses must have no effect
    tick();
    left_p = 1'b1; rot_p = 1'b1;
    tick();
    left_p = 1'b0; rot_p = 1'b0;
    tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_code", cmd_code, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_dropped", dropped, 0);

    // Release with gravity at level 0: FALL visible 21 edges later
    gravity_en = 1'b1;
    rst_n = 1'b1;
    repeat (20) tick();
    chk("grav0_pre_valid", cmd_valid, 0);
    tick();
    chk("grav0_valid", cmd_valid, 1);
    chk("grav0_code", cmd_code, 4);
    chk("grav0_count", fifo_count, 1);
    cmd_ready = 1'b1; gravity_en = 1'b0;
    tick();
    chk("grav0_pop_count", fifo_count, 0);
    chk("grav0_pop_code", cmd_code, 0);

    // Single LEFT press
    left_p = 1'b1;
    tick();
    left_p = 1'b0;
    chk("left_lat_valid", cmd_valid, 0);
    tick();
    chk("left_valid", cmd_valid, 1);
    chk("left_code", cmd_code, 1);
    chk("left_count", fifo_count, 1);
    tick();
    chk("left_pop_count", fifo_count, 0);
    chk("left_pop_valid", cmd_valid, 0);

    // Simultaneous LEFT/ROT/DROP: order 5,3,1
    cmd_ready = 1'b0;
    left_p = 1'b1; rot_p = 1'b1; drop_p = 1'b1;
    tick();
    left_p = 1'b0; rot_p = 1'b0; drop_p = 1'b0;
    chk("sim_count0", fifo_count, 0);
    tick();
    chk("sim_count1", fifo_count, 1);
    chk("sim_head1", cmd_code, 5);
    tick();
    chk("sim_count2", fifo_count, 2);
    tick();
    chk("sim_count3", fifo_count, 3);
    chk("sim_head_drop", cmd_code, 5);
    cmd_ready = 1'b1;
    tick();
    chk("sim_head_rot", cmd_code, 3);
    chk("sim_cnt_after1", fifo_count, 2);
    tick();
    chk("sim_head_left", cmd_code, 1);
    tick();
    chk("sim_empty_valid", cmd_valid, 0);
    chk("sim_empty_code", cmd_code, 0);
    cmd_ready = 1'b0;

    // Overflow and coalescing
    drop_p = 1'b1; rot_p = 1'b1; left_p = 1'b1; right_p = 1'b1;
    tick();
    drop_p = 1'b0; rot_p = 1'b0; left_p = 1'b0; right_p = 1'b0;
    repeat (4) tick();
    chk("ovf_count_full", fifo_count, 4);
    chk("ovf_head", cmd_code, 5);
    rot_p = 1'b1;
    tick();
    rot_p = 1'b0;
    chk("ovf_first_rot_dropped", dropped, 0);
    tick();
    chk("ovf_idle_dropped", dropped, 0);
    rot_p = 1'b1;
    tick();
    rot_p = 1'b0;
    chk("ovf_coalesce_dropped", dropped, 1);
    chk("ovf_coalesce_count", fifo_count, 4);
    tick();
    chk("ovf_dropped_pulse_end", dropped, 0);
    cmd_ready = 1'b1;
    tick();
    chk("ovf_pushpop_count", fifo_count, 4);
    chk("ovf_pop1_code", cmd_code, 3);
    tick();
    chk("ovf_pop2_count", fifo_count, 3);
    chk("ovf_pop2_code", cmd_code, 1);
    tick();
    chk("ovf_pop3_code", cmd_code, 2);
    tick();
    chk("ovf_pop4_code", cmd_code, 3);
    chk("ovf_pop4_count", fifo_count, 1);
    tick();
    chk("ovf_drain_valid", cmd_valid, 0);

    // Level 5 saturates to period 6
    level = 4'd5; gravity_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      chk($sformatf("lvl5_valid_k%0d", k), cmd_valid, (k == 7 || k == 13) ? 1 : 0);
      chk($sformatf("lvl5_code_k%0d", k), cmd_code, (k == 7 || k == 13) ? 4 : 0);
    end
    gravity_en = 1'b0;
    tick();
    chk("lvl5_stop_valid", cmd_valid, 0);

    // Level 0 -> 3 at count 15: fire on next edge, then every 8
    level = 4'd0; gravity_en = 1'b1;
    repeat (15) tick();
    chk("lvlchg_pre_valid", cmd_valid, 0);
    level = 4'd3;
    tick();
    chk("lvlchg_pend_valid", cmd_valid, 0);
    tick();
    chk("lvlchg_fire_valid", cmd_valid, 1);
    chk("lvlchg_fire_code", cmd_code, 4);
    for (int k = 18; k <= 25; k++) begin
      tick();
      chk($sformatf("lvl3_valid_k%0d", k), cmd_valid, (k == 25) ? 1 : 0);
    end
    gravity_en = 1'b0; level = 4'd0;
    tick();
    chk("lvl3_stop_valid", cmd_valid, 0);

    // Clear with a ROT press in the same cycle
    cmd_ready = 1'b0;
    left_p = 1'b1; right_p = 1'b1; rot_p = 1'b1;
    tick();
    left_p = 1'b0; right_p = 1'b0; rot_p = 1'b0;
    repeat (3) tick();
    chk("clr_pre_count", fifo_count, 3);
    chk("clr_pre_head", cmd_code, 3);
    clear = 1'b1; rot_p = 1'b1;
    tick();
    clear = 1'b0; rot_p = 1'b0;
    chk("clr_valid", cmd_valid, 0);
    chk("clr_count", fifo_count, 0);
    chk("clr_code", cmd_code, 0);
    chk("clr_dropped", dropped, 0);
    repeat (3) tick();
    chk("clr_no_rot_valid", cmd_valid, 0);
    chk("clr_no_rot_count", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
